// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one period counter, with double-buffered duties,
// per-channel enable/polarity, run-time edge/center modulation and a period-start strobe.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int DUTY_W   = 8,
  parameter int PERIOD   = 2500,
  parameter int SCALE    = 10,
  parameter int DUTY_MAX = 250
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       mode_center,
  input  logic [CHANNELS*DUTY_W-1:0] duty_in,
  input  logic                       duty_load,
  input  logic [CHANNELS-1:0]        ch_enable,
  input  logic [CHANNELS-1:0]        polarity,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic                       period_start,
  output logic                       update_pending
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int CMP_W = DUTY_W + $clog2(SCALE) + 1;
  localparam int CMPX_W = (CNT_W > CMP_W) ? CNT_W : CMP_W;
  localparam int HALF  = PERIOD / 2;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       dir_q, dir_d;   // 0 = counting up, 1 = counting down
  logic                       mode_q;
  logic [CHANNELS*DUTY_W-1:0] pending_q, active_q;
  logic [CHANNELS-1:0]        pwm_q, pwm_d, raw;
  logic                       period_start_q, update_pending_q;
  logic                       last, transfer;

  // Compare is widened so duty*SCALE never truncates.
  function automatic logic raw_level(input logic [DUTY_W-1:0] duty,
                                     input logic              center,
                                     input logic [CNT_W-1:0]  cnt);
    logic [CMP_W-1:0] cmp;
    logic [CMP_W-1:0] thr;
    cmp = CMP_W'(duty) * CMP_W'(SCALE);
    thr = center ? (cmp >> 1) : cmp;
    if (32'(duty) >= 32'(DUTY_MAX)) return 1'b1;
    if (duty == '0) return 1'b0;
    return (CMPX_W'(cnt) < CMPX_W'(thr));
  endfunction

  always_comb begin
    last     = mode_q ? ((cnt_q == '0) && dir_q) : (cnt_q == CNT_W'(PERIOD - 1));
    transfer = !enable || last;
  end

  // Center mode holds each end value for one extra cycle so both modes span PERIOD cycles.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable || last) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!dir_q) begin
      if (cnt_q == CNT_W'(HALF - 1)) dir_d = 1'b1;
      else                           cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = raw_level(active_q[i*DUTY_W +: DUTY_W], mode_q, cnt_q);
    end
    pwm_d = (raw & ch_enable & {CHANNELS{enable}}) ^ polarity;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q            <= '0;
      dir_q            <= 1'b0;
      mode_q           <= 1'b0;
      pending_q        <= '0;
      active_q         <= '0;
      pwm_q            <= '0;
      period_start_q   <= 1'b0;
      update_pending_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pwm_q          <= pwm_d;
      period_start_q <= enable && (cnt_q == '0) && !dir_q;
      if (duty_load) pending_q <= duty_in;
      // A load coinciding with the transfer lands one period later.
      if (transfer) begin
        active_q <= pending_q;
        mode_q   <= mode_center;
      end
      if (duty_load)     update_pending_q <= 1'b1;
      else if (transfer) update_pending_q <= 1'b0;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_start   = period_start_q;
  assign update_pending = update_pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: per-period measurements of high time, transitions and
// strobes, checked against expectations queued when the stimulus is applied.
module tb_pwm_multi_channel;

  localparam int CH     = 4;
  localparam int DW     = 8;
  localparam int PERIOD = 2500;
  localparam int SCALE  = 10;
  localparam int DMAX   = 250;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              mode_center;
  logic [CH*DW-1:0]  duty_in;
  logic              duty_load;
  logic [CH-1:0]     ch_enable;
  logic [CH-1:0]     polarity;
  logic [CH-1:0]     pwm_out;
  logic              period_start;
  logic              update_pending;

  logic [31:0]       exp_q[$];
  logic [31:0]       e;
  logic [CH*DW-1:0]  dv;
  int                n_cmp = 0;
  int                n_fail = 0;

  int                m_high[CH];
  int                m_trans[CH];
  logic [CH-1:0]     m_first, m_last;
  int                m_ps, m_wait;
  logic              m_upd_load, m_upd_pre, m_upd_end;

  pwm_multi_channel #(
    .CHANNELS(CH), .DUTY_W(DW), .PERIOD(PERIOD), .SCALE(SCALE), .DUTY_MAX(DMAX)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .mode_center    (mode_center),
    .duty_in        (duty_in),
    .duty_load      (duty_load),
    .ch_enable      (ch_enable),
    .polarity       (polarity),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ps();
    m_wait = 0;
    while (period_start !== 1'b1 && m_wait < 3*PERIOD) begin
      tick();
      m_wait++;
    end
    n_cmp++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_period_start: got %b expected 1 within %0d cycles", period_start, 3*PERIOD);
    end
  endtask

  // Observes one full period starting at a period_start sample; optionally loads duties at sample load_at.
  task automatic measure(input int load_at, input logic [CH*DW-1:0] load_val);
    logic [CH-1:0] prev;
    wait_ps();
    m_ps       = 0;
    m_first    = pwm_out;
    prev       = pwm_out;
    m_upd_load = 1'b0;
    m_upd_pre  = 1'b0;
    m_upd_end  = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_high[c]  = 0;
      m_trans[c] = 0;
    end
    for (int k = 0; k < PERIOD; k++) begin
      if (period_start === 1'b1) m_ps++;
      for (int c = 0; c < CH; c++) begin
        if (pwm_out[c] === 1'b1) m_high[c]++;
        if (k > 0 && pwm_out[c] !== prev[c]) m_trans[c]++;
      end
      prev = pwm_out;
      if (k == load_at + 1) m_upd_load = update_pending;
      if (k == PERIOD - 2)  m_upd_pre  = update_pending;
      if (k == PERIOD - 1)  m_upd_end  = update_pending;
      if (k == load_at) begin
        duty_in   = load_val;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
      end else begin
        tick();
      end
    end
    m_last = prev;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; mode_center = 1'b0; duty_load = 1'b0;
    duty_in = '0; ch_enable = '1; polarity = 4'b1010;
    repeat (3) tick();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out) !== e) begin n_fail++; $display("FAIL reset_pwm: got %b expected %0d", pwm_out, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL reset_ps: got %b expected %0d", period_start, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(update_pending) !== e) begin n_fail++; $display("FAIL reset_upd: got %b expected %0d", update_pending, e); end
    reset = 1'b1;
    tick(); tick();
    exp_q.push_back(32'(4'b1010));
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out) !== e) begin n_fail++; $display("FAIL disabled_pwm_is_polarity: got %b expected %b", pwm_out, e[CH-1:0]); end
    dv = '0;
    dv[0 +: DW] = DW'(100);
    duty_in = dv; duty_load = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    duty_load = 1'b0;
    e = exp_q.pop_front(); n_cmp++; if (32'(update_pending) !== e) begin n_fail++; $display("FAIL disabled_load_upd: got %b expected %0d", update_pending, e); end
    tick();
    e = exp_q.pop_front(); n_cmp++; if (32'(update_pending) !== e) begin n_fail++; $display("FAIL disabled_upd_clear: got %b expected %0d", update_pending, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL disabled_ps: got %b expected %0d", period_start, e); end
  endtask

  task automatic test_edge();
    polarity = '0;
    enable   = 1'b1;
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL enable_first_ps: got %b expected %0d", period_start, e); end
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(32'd0); exp_q.push_back(32'd1000); exp_q.push_back(32'd1);
      exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      measure(-1, dv);
      e = exp_q.pop_front(); n_cmp++; if (32'(m_wait) !== e) begin n_fail++; $display("FAIL edge_ps_spacing: got wait %0d expected %0d", m_wait, e); end
      e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL edge_high_ch0: got %0d expected %0d", m_high[0], e); end
      e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[0]) !== e) begin n_fail++; $display("FAIL edge_trans_ch0: got %0d expected %0d", m_trans[0], e); end
      e = exp_q.pop_front(); n_cmp++; if (32'(m_first[0]) !== e) begin n_fail++; $display("FAIL edge_first_ch0: got %0d expected %0d", m_first[0], e); end
      e = exp_q.pop_front(); n_cmp++; if (32'(m_ps) !== e) begin n_fail++; $display("FAIL edge_ps_count: got %0d expected %0d", m_ps, e); end
      e = exp_q.pop_front(); n_cmp++; if (32'(m_high[1]) !== e) begin n_fail++; $display("FAIL edge_high_ch1_zero: got %0d expected %0d", m_high[1], e); end
    end
  endtask

  task automatic test_duty_sweep();
    int vals[5];
    vals = '{0, 250, 255, 1, 0};
    vals[4] = int'($urandom_range(2, 249));
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        dv[DW +: DW] = DW'(vals[i]);
        dv[0 +: DW]  = DW'($urandom_range(0, 255));
        exp_q.push_back((vals[i] >= DMAX) ? 32'(PERIOD) : 32'(vals[i] * SCALE));
        exp_q.push_back((vals[i] == 0 || vals[i] >= DMAX) ? 32'd0 : 32'd1);
      end
      measure((i < 5) ? 5 : -1, dv);
      if (i > 0) begin
        e = exp_q.pop_front(); n_cmp++; if (32'(m_high[1]) !== e) begin n_fail++; $display("FAIL sweep_high_ch1 duty=%0d: got %0d expected %0d", vals[i-1], m_high[1], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[1]) !== e) begin n_fail++; $display("FAIL sweep_trans_ch1 duty=%0d: got %0d expected %0d", vals[i-1], m_trans[1], e); end
      end
    end
  endtask

  task automatic test_shadow();
    dv = '0;
    dv[0 +: DW] = DW'(100);
    measure(5, dv);
    dv[0 +: DW] = DW'(50);
    exp_q.push_back(32'd1000); exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    measure(300, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL shadow_keep_old: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_load) !== e) begin n_fail++; $display("FAIL shadow_upd_set: got %0d expected %0d", m_upd_load, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_pre) !== e) begin n_fail++; $display("FAIL shadow_upd_hold: got %0d expected %0d", m_upd_pre, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_end) !== e) begin n_fail++; $display("FAIL shadow_upd_clear: got %0d expected %0d", m_upd_end, e); end
    dv[0 +: DW] = DW'(80);
    exp_q.push_back(32'd500); exp_q.push_back(32'd1);
    measure(PERIOD - 2, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL shadow_new_applied: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_end) !== e) begin n_fail++; $display("FAIL last_load_upd_stays: got %0d expected %0d", m_upd_end, e); end
    exp_q.push_back(32'd500); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL last_load_deferred: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_pre) !== e) begin n_fail++; $display("FAIL last_load_upd_pre: got %0d expected %0d", m_upd_pre, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_upd_end) !== e) begin n_fail++; $display("FAIL last_load_upd_end: got %0d expected %0d", m_upd_end, e); end
    exp_q.push_back(32'd800);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL last_load_applied: got %0d expected %0d", m_high[0], e); end
  endtask

  task automatic test_center();
    dv = '0;
    dv[0 +: DW]    = DW'(100);
    dv[DW +: DW]   = DW'(1);
    dv[2*DW +: DW] = DW'(100);
    mode_center = 1'b1;
    exp_q.push_back(32'd800); exp_q.push_back(32'd1);
    measure(5, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL center_deferred_high: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[0]) !== e) begin n_fail++; $display("FAIL center_deferred_trans: got %0d expected %0d", m_trans[0], e); end
    exp_q.push_back(32'd1000); exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    exp_q.push_back(32'd10);   exp_q.push_back(32'd1);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL center_high: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[0]) !== e) begin n_fail++; $display("FAIL center_trans: got %0d expected %0d", m_trans[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_first[0]) !== e) begin n_fail++; $display("FAIL center_first: got %0d expected %0d", m_first[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_last[0]) !== e) begin n_fail++; $display("FAIL center_last: got %0d expected %0d", m_last[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[1]) !== e) begin n_fail++; $display("FAIL center_duty1_high: got %0d expected %0d", m_high[1], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_ps) !== e) begin n_fail++; $display("FAIL center_ps_count: got %0d expected %0d", m_ps, e); end
    mode_center = 1'b0;
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1000);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[0]) !== e) begin n_fail++; $display("FAIL mode_toggle_deferred: got %0d expected %0d", m_trans[0], e); end
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[0]) !== e) begin n_fail++; $display("FAIL edge_restored_trans: got %0d expected %0d", m_trans[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_last[0]) !== e) begin n_fail++; $display("FAIL edge_restored_last: got %0d expected %0d", m_last[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL edge_restored_high: got %0d expected %0d", m_high[0], e); end
  endtask

  task automatic test_polarity();
    polarity[2]  = 1'b1;
    ch_enable[2] = 1'b0;
    tick();
    exp_q.push_back(32'(PERIOD)); exp_q.push_back(32'd0);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[2]) !== e) begin n_fail++; $display("FAIL pol_disabled_high: got %0d expected %0d", m_high[2], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_trans[2]) !== e) begin n_fail++; $display("FAIL pol_disabled_trans: got %0d expected %0d", m_trans[2], e); end
    repeat (199) tick();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out[2]) !== e) begin n_fail++; $display("FAIL pol_before_enable: got %b expected %0d", pwm_out[2], e); end
    ch_enable[2] = 1'b1;
    tick();
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out[2]) !== e) begin n_fail++; $display("FAIL pol_enable_latency: got %b expected %0d", pwm_out[2], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL pol_no_restart: got %b expected %0d", period_start, e); end
    repeat (799) tick();
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out[2]) !== e) begin n_fail++; $display("FAIL pol_active_end: got %b expected %0d", pwm_out[2], e); end
    tick();
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out[2]) !== e) begin n_fail++; $display("FAIL pol_inactive_start: got %b expected %0d", pwm_out[2], e); end
  endtask

  task automatic test_async_reset();
    polarity  = '0;
    ch_enable = '1;
    dv = '0;
    dv[0 +: DW]    = DW'(200);
    dv[3*DW +: DW] = DW'(255);
    measure(5, dv);
    wait_ps();
    repeat (1232) tick();
    dv[DW +: DW] = DW'(7);
    duty_in = dv; duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    exp_q.push_back(32'(4'b1001)); exp_q.push_back(32'd1);
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out) !== e) begin n_fail++; $display("FAIL pre_reset_pwm: got %b expected %b", pwm_out, e[CH-1:0]); end
    e = exp_q.pop_front(); n_cmp++; if (32'(update_pending) !== e) begin n_fail++; $display("FAIL pre_reset_upd: got %b expected %0d", update_pending, e); end
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out) !== e) begin n_fail++; $display("FAIL async_reset_pwm: got %b expected %0d", pwm_out, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL async_reset_ps: got %b expected %0d", period_start, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(update_pending) !== e) begin n_fail++; $display("FAIL async_reset_upd: got %b expected %0d", update_pending, e); end
    #3 reset = 1'b1;
    tick();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_cmp++; if (32'(period_start) !== e) begin n_fail++; $display("FAIL release_first_ps: got %b expected %0d", period_start, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(pwm_out) !== e) begin n_fail++; $display("FAIL release_pwm: got %b expected %0d", pwm_out, e); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    measure(-1, dv);
    e = exp_q.pop_front(); n_cmp++; if (32'(m_wait) !== e) begin n_fail++; $display("FAIL release_aligned: got wait %0d expected %0d", m_wait, e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[0]) !== e) begin n_fail++; $display("FAIL release_duty0_ch0: got %0d expected %0d", m_high[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_high[3]) !== e) begin n_fail++; $display("FAIL release_duty0_ch3: got %0d expected %0d", m_high[3], e); end
    e = exp_q.pop_front(); n_cmp++; if (32'(m_ps) !== e) begin n_fail++; $display("FAIL release_ps_count: got %0d expected %0d", m_ps, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_edge();
    test_duty_sweep();
    test_shadow();
    test_center();
    test_polarity();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised N-channel PWM generator that shares one period counter across all channels. Each channel has its own double-buffered duty register, enable and output polarity. Edge-aligned or center-aligned modulation is selectable at run time. It is the drop-in successor for single-channel motor/servo PWM, and also exports a period-start strobe for ADC/control-loop synchronisation.

Parameters:
CHANNELS, 4, number of independent PWM outputs
DUTY_W, 8, width of each channel's duty code
PERIOD, 2500, clock cycles per PWM period; must be even and >= DUTY_MAX*SCALE
SCALE, 10, clock cycles per duty LSB (compare = duty*SCALE)
DUTY_MAX, 250, duty code at or above which the output is 100% active

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  global run; 0 holds counter at 0, outputs inactive
mode_center  in  1  0 = edge-aligned, 1 = center-aligned; applied at period boundary
duty_in  in  CHANNELS*DUTY_W  packed duty codes, channel i at [i*DUTY_W +: DUTY_W]
duty_load  in  1  1-cycle strobe: capture all of duty_in into pending registers
ch_enable  in  CHANNELS  per-channel enable
polarity  in  CHANNELS  per-channel invert (1 = active-low output)
pwm_out  out  CHANNELS  registered PWM outputs
period_start  out  1  1-cycle pulse on the first cycle of each period
update_pending  out  1  pending duties not yet applied

Behaviour:
- Reset (reset=0, async): cnt=0, dir=up, pending/active duties=0, active mode=edge, pwm_out=0, period_start=0, update_pending=0.
- Counter width: clog2(PERIOD).
- Edge mode: cnt runs 0..PERIOD-1, then wraps to 0.
- Center mode: cnt runs up 0..PERIOD/2-1, then down PERIOD/2-1..0. Each end value is held once, giving PERIOD cycles per period.
- Wrap cycle ("last"): edge mode cnt==PERIOD-1; center mode cnt==0 with dir=down.
- Compare: cmp_i = active_duty_i*SCALE, computed at DUTY_W+clog2(SCALE)+1 bits. No truncation is allowed.
- Raw level:
  - active_duty_i >= DUTY_MAX -> 1 (always on).
  - active_duty_i == 0 -> 0.
  - Else, edge mode: cnt < cmp_i.
  - Else, center mode: cnt < (cmp_i>>1), i.e. 2*(cmp_i>>1) active cycles centred on cnt=0.
- pwm_out[i] is registered: value at edge t+1 = (raw level from cnt at t AND ch_enable[i] AND enable) XOR polarity[i]. Latency is 1 cycle.
- A disabled channel drives polarity[i] (inactive level). Disabling or enabling takes effect with 1-cycle latency, mid-period, with no period restart.
- Shadowing:
  - duty_load=1: pending <= duty_in and update_pending <= 1.
  - On the last cycle: active <= pending, active mode <= mode_center, update_pending <= 0.
- duty_load on the same cycle as last: active takes the old pending value, pending takes the new duty_in, and update_pending stays 1. The new value applies one period later.
- enable=0:
  - cnt=0, dir=up, period_start=0.
  - Every cycle: active <= pending, mode <= mode_center, update_pending <= 0.
  - duty_load is still accepted.
- enable 0->1: counting starts from cnt=0 with period_start=1 on that cycle. pwm_out reflects the new period from the next edge.
- period_start=1 on each registered cycle where cnt==0 begins a new period (after wrap, or first enabled cycle).
- reset asserted mid-period: everything returns to reset values immediately, with no completion of the current pulse.

Test Plan:
- Defaults, enable=1, ch0 duty=100, polarity=0 -> pwm_out[0] high 1000 cycles, low 1500, period_start every 2500 cycles.
- Duty sweep ch1: 0 -> never high. 250 and 255 -> always high. 1 -> exactly 10 high cycles per period.
- duty_load mid-period (ch0 100->50) -> current period keeps 1000 high cycles, next period 500. update_pending 1 until wrap. duty_load exactly on the last cycle -> applies one period later.
- Center mode, duty=100 -> 1000 high cycles contiguous, centred on the period boundary. Toggling mode_center mid-period -> takes effect only after wrap.
- polarity[2]=1, ch_enable[2]=0 -> pwm_out[2]=1 constant. Enable mid-period -> inverted PWM from the next cycle.
- Assert reset (low) at cnt=1234 with outputs high -> all outputs 0 and cnt 0 asynchronously. After release with enable=1 -> period_start on the first clock.
